// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/writeback sequencer for the ALU opcode/result interface.
// Accepts one instruction per handshake, drives the ALU for EXEC_CYCLES,
// captures the 64-bit result into Z and writes back Rc (32-bit ops) or
// LO then HI (MUL/DIV).
// Optional build macro ALU_FLAGS_EN adds registered flag_z/flag_n outputs.
module alu_issue_ctrl #(
  parameter int unsigned EXEC_CYCLES = 2,
  parameter int unsigned REG_AW      = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [4:0]        alu_opcode,
  output logic [REG_AW-1:0] rd_a_sel,
  output logic [REG_AW-1:0] rd_b_sel,
  input  logic [63:0]       alu_result,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_sel,
  output logic [31:0]       wb_data,
  output logic              lo_en,
  output logic              hi_en,
  output logic [31:0]       hilo_data,
`ifdef ALU_FLAGS_EN
  output logic              flag_z,
  output logic              flag_n,
`endif
  output logic              done,
  output logic              illegal
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXEC  = 3'd1,
    S_CAPT  = 3'd2,
    S_WB    = 3'd3,
    S_WB_HI = 3'd4
  } state_e;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_AND  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_SHR  = 5'b00111,
    OP_SHRA = 5'b01000,
    OP_SHL  = 5'b01001,
    OP_ROR  = 5'b01010,
    OP_ROL  = 5'b01011,
    OP_MUL  = 5'b01111,
    OP_DIV  = 5'b10000,
    OP_NEG  = 5'b10001,
    OP_NOT  = 5'b10010
  } op_e;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_e      r_state;
  state_e      w_next;
  logic [16:0] r_ir;        // instr[31:15]: opcode, Ra, Rb, Rc
  logic [63:0] r_z;
  logic [3:0]  r_cnt;
  logic        r_illegal;

  logic        w_accept;
  logic        w_legal;
  logic [4:0]  w_ir_op;
  logic        w_muldiv;
  logic        w_unused_instr;

  assign w_ir_op        = r_ir[16:12];
  assign w_muldiv       = (w_ir_op == OP_MUL) || (w_ir_op == OP_DIV);
  assign w_accept       = (r_state == S_IDLE) && instr_valid;
  assign w_unused_instr = ^instr[14:0];
  assign illegal        = r_illegal;

  // Opcode legality of the incoming instruction
  always_comb begin
    w_legal = 1'b0;
    case (instr[31:27])
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT: w_legal = 1'b1;
      default:                                        w_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge clear) begin
    if (clear) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Instruction latch, execute counter, result capture and illegal pulse
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_ir      <= '0;
      r_z       <= '0;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_accept && !w_legal;
      if (w_accept) begin
        r_ir  <= instr[31:15];
        r_cnt <= CNT_INIT;
      end
      if (r_state == S_EXEC && r_cnt != '0) r_cnt <= r_cnt - 4'd1;
      if (r_state == S_CAPT) r_z <= alu_result;
    end
  end

`ifdef ALU_FLAGS_EN
  logic r_flag_z;
  logic r_flag_n;

  assign flag_z = r_flag_z;
  assign flag_n = r_flag_n;

  // Flags follow the width of the op: 64-bit for MUL/DIV, low word otherwise
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
    end else if (r_state == S_CAPT) begin
      if (w_muldiv) begin
        r_flag_z <= (alu_result == 64'd0);
        r_flag_n <= alu_result[63];
      end else begin
        r_flag_z <= (alu_result[31:0] == 32'd0);
        r_flag_n <= alu_result[31];
      end
    end
  end
`endif

  // Next-state and output decode
  always_comb begin
    w_next      = r_state;
    instr_ready = 1'b0;
    alu_opcode  = '0;
    rd_a_sel    = '0;
    rd_b_sel    = '0;
    wb_en       = 1'b0;
    wb_sel      = '0;
    wb_data     = '0;
    lo_en       = 1'b0;
    hi_en       = 1'b0;
    hilo_data   = '0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid && w_legal) w_next = S_EXEC;
      end
      S_EXEC: begin
        alu_opcode = w_ir_op;
        rd_a_sel   = REG_AW'(r_ir[11:8]);
        rd_b_sel   = REG_AW'(r_ir[7:4]);
        if (r_cnt == '0) w_next = S_CAPT;
      end
      S_CAPT: begin
        alu_opcode = w_ir_op;
        rd_a_sel   = REG_AW'(r_ir[11:8]);
        rd_b_sel   = REG_AW'(r_ir[7:4]);
        w_next     = S_WB;
      end
      S_WB: begin
        if (w_muldiv) begin
          lo_en     = 1'b1;
          hilo_data = r_z[31:0];
          w_next    = S_WB_HI;
        end else begin
          wb_en   = 1'b1;
          wb_sel  = REG_AW'(r_ir[3:0]);
          wb_data = r_z[31:0];
          done    = 1'b1;
          w_next  = S_IDLE;
        end
      end
      S_WB_HI: begin
        hi_en     = 1'b1;
        hilo_data = r_z[63:32];
        done      = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: table of directed instructions
// plus hand-written reset, abort and back-to-back sequences. A small ALU
// model turns the register-file reads into alu_result.
module tb_alu_issue_ctrl;

  localparam int unsigned EXEC = 2;

  logic        clock = 1'b0;
  logic        clear;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  alu_opcode;
  logic [3:0]  rd_a_sel, rd_b_sel, wb_sel;
  logic [63:0] alu_result;
  logic        wb_en, lo_en, hi_en, done, illegal;
  logic [31:0] wb_data, hilo_data;
`ifdef ALU_FLAGS_EN
  logic        flag_z, flag_n;
`endif

  logic [31:0] regs [16];
  int          total = 0;
  int          bad   = 0;

  alu_issue_ctrl #(.EXEC_CYCLES(EXEC), .REG_AW(4)) dut (
    .clock(clock), .clear(clear),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_opcode(alu_opcode), .rd_a_sel(rd_a_sel), .rd_b_sel(rd_b_sel),
    .alu_result(alu_result),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
    .lo_en(lo_en), .hi_en(hi_en), .hilo_data(hilo_data),
`ifdef ALU_FLAGS_EN
    .flag_z(flag_z), .flag_n(flag_n),
`endif
    .done(done), .illegal(illegal)
  );

  always #5 clock = ~clock;

  // Reference ALU; upper word of 32-bit ops carries junk that must be ignored
  always_comb begin
    logic [31:0] a, b, r;
    logic [63:0] t;
    a = regs[rd_a_sel];
    b = regs[rd_b_sel];
    r = '0;
    t = '0;
    alu_result = '0;
    case (alu_opcode)
      5'b00011: r = a + b;
      5'b00100: r = a - b;
      5'b00101: r = a & b;
      5'b00110: r = a | b;
      5'b00111: r = a >> b[4:0];
      5'b01000: r = $signed(a) >>> b[4:0];
      5'b01001: r = a << b[4:0];
      5'b01010: begin t = {a, a} >> b[4:0]; r = t[31:0];  end
      5'b01011: begin t = {a, a} << b[4:0]; r = t[63:32]; end
      5'b10001: r = -a;
      5'b10010: r = ~a;
      default:  r = '0;
    endcase
    if (alu_opcode == 5'b01111)
      alu_result = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    else if (alu_opcode == 5'b10000)
      alu_result = (b == 0) ? 64'd0 : {a % b, a / b};
    else if (alu_opcode != 5'b00000)
      alu_result = {32'hA5A5A5A5, r};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [3:0]  ra, rb, rc;
    logic [31:0] a, b;
    int          kind;    // 0 = 32-bit, 1 = MUL/DIV, 2 = illegal
    logic [31:0] exp_lo, exp_hi;
  } vec_t;

  vec_t vecs [12];

  // Issue one instruction and watch 8 cycles of outputs after acceptance
  task automatic run_vec(input vec_t v);
    int nwb = 0, nlo = 0, nhi = 0, ndone = 0, nill = 0;
    int kwb = 0, klo = 0, khi = 0, kdone = 0, kill = 0;
    int opc_err = 0, sel_err = 0, rdy_err = 0, multi = 0;
    logic [31:0] d_wb = '0, d_lo = '0, d_hi = '0;
    logic [3:0]  s_wb = '0;
    int lat;
    logic [4:0] eop;
    lat = (v.kind == 1) ? EXEC + 3 : (v.kind == 0) ? EXEC + 2 : 0;
    regs[v.ra] = v.a;
    regs[v.rb] = v.b;
    instr = {v.op, v.ra, v.rb, v.rc, 15'h2A55};
    instr_valid = 1'b1;
    chk("ready_before_accept", instr_ready, 1);
    @(posedge clock); #1;
    instr_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      eop = (v.kind != 2 && k <= EXEC + 1) ? v.op : 5'b00000;
      if (alu_opcode !== eop) opc_err++;
      if (v.kind != 2 && k <= EXEC + 1 && (rd_a_sel !== v.ra || rd_b_sel !== v.rb)) sel_err++;
      if (instr_ready !== (k > lat)) rdy_err++;
      if ((int'(wb_en) + int'(lo_en) + int'(hi_en)) > 1) multi++;
      if (wb_en)   begin nwb++; kwb = k; d_wb = wb_data; s_wb = wb_sel; end
      if (lo_en)   begin nlo++; klo = k; d_lo = hilo_data; end
      if (hi_en)   begin nhi++; khi = k; d_hi = hilo_data; end
      if (done)    begin ndone++; kdone = k; end
      if (illegal) begin nill++; kill = k; end
      @(posedge clock); #1;
    end
    chk("opcode_window", 64'(opc_err), 0);
    chk("read_selects", 64'(sel_err), 0);
    chk("ready_busy", 64'(rdy_err), 0);
    chk("strobe_onehot", 64'(multi), 0);
    if (v.kind == 0) begin
      chk("wb_count", 64'(nwb), 1);
      chk("wb_latency", 64'(kwb), 64'(EXEC + 2));
      chk("wb_sel", s_wb, v.rc);
      chk("wb_data", d_wb, v.exp_lo);
      chk("hilo_none", 64'(nlo + nhi), 0);
      chk("done_with_wb", 64'({ndone, kdone}), 64'({32'd1, kwb}));
      chk("no_illegal", 64'(nill), 0);
    end else if (v.kind == 1) begin
      chk("lo_count_cycle", 64'({nlo, klo}), 64'({32'd1, EXEC + 2}));
      chk("lo_data", d_lo, v.exp_lo);
      chk("hi_count_cycle", 64'({nhi, khi}), 64'({32'd1, EXEC + 3}));
      chk("hi_data", d_hi, v.exp_hi);
      chk("wb_none", 64'(nwb), 0);
      chk("done_with_hi", 64'({ndone, kdone}), 64'({32'd1, EXEC + 3}));
    end else begin
      chk("illegal_pulse", 64'({nill, kill}), 64'({32'd1, 32'd1}));
      chk("illegal_no_activity", 64'(nwb + nlo + nhi + ndone), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = '0;
    //          op        ra    rb    rc    a             b        kind lo            hi
    vecs[0]  = '{5'b00011, 4'd1, 4'd2, 4'd3,  32'd5,        32'd7,   0, 32'd12,       32'd0};
    vecs[1]  = '{5'b00100, 4'd4, 4'd5, 4'd6,  32'd9,        32'd4,   0, 32'd5,        32'd0};
    vecs[2]  = '{5'b00101, 4'd1, 4'd2, 4'd7,  32'h0000F0F0, 32'hFF00, 0, 32'h0000F000, 32'd0};
    vecs[3]  = '{5'b00110, 4'd1, 4'd2, 4'd8,  32'h0000F0F0, 32'hFF00, 0, 32'h0000FFF0, 32'd0};
    vecs[4]  = '{5'b01001, 4'd1, 4'd2, 4'd9,  32'd1,        32'd4,   0, 32'h00000010, 32'd0};
    vecs[5]  = '{5'b01000, 4'd1, 4'd2, 4'd10, 32'h80000000, 32'd4,   0, 32'hF8000000, 32'd0};
    vecs[6]  = '{5'b01011, 4'd1, 4'd2, 4'd11, 32'h80000001, 32'd1,   0, 32'h00000003, 32'd0};
    vecs[7]  = '{5'b10010, 4'd1, 4'd2, 4'd15, 32'd0,        32'd0,   0, 32'hFFFFFFFF, 32'd0};
    vecs[8]  = '{5'b01111, 4'd1, 4'd2, 4'd0,  32'h00010000, 32'h00010000, 1, 32'h0, 32'h1};
    vecs[9]  = '{5'b10000, 4'd1, 4'd2, 4'd0,  32'd100,      32'd7,   1, 32'd14,       32'd2};
    vecs[10] = '{5'b11111, 4'd1, 4'd2, 4'd3,  32'd1,        32'd1,   2, 32'd0,        32'd0};
    vecs[11] = '{5'b00000, 4'd1, 4'd2, 4'd3,  32'd1,        32'd1,   2, 32'd0,        32'd0};

    clear = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_ctrl_outs", {alu_opcode, rd_a_sel, rd_b_sel, wb_sel, wb_en, lo_en, hi_en, done, illegal}, 0);
    chk("reset_data_outs", {wb_data, hilo_data}, 0);
`ifdef ALU_FLAGS_EN
    chk("reset_flags", {flag_z, flag_n}, 0);
`endif
    @(negedge clock); clear = 1'b0;
    @(posedge clock); #1;
    chk("ready_after_reset", instr_ready, 1);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Abort a DIV while the HI write is pending
    regs[1] = 32'd100; regs[2] = 32'd7;
    instr = {5'b10000, 4'd1, 4'd2, 4'd0, 15'd0};
    instr_valid = 1'b1;
    @(posedge clock); #1;
    instr_valid = 1'b0;
    repeat (EXEC + 1) begin @(posedge clock); #1; end
    chk("abort_lo_seen", {lo_en, hilo_data}, {1'b1, 32'd14});
    @(posedge clock); #1;
    clear = 1'b1;
    #1;
    chk("abort_outs", {hi_en, lo_en, wb_en, done, alu_opcode, hilo_data, wb_data}, 0);
    begin
      int hi_seen = 0;
      repeat (2) begin @(posedge clock); #1; if (hi_en || done) hi_seen++; end
      @(negedge clock); clear = 1'b0;
      @(posedge clock); #1;
      chk("abort_ready", instr_ready, 1);
      repeat (6) begin if (hi_en || lo_en || wb_en || done) hi_seen++; @(posedge clock); #1; end
      chk("abort_no_late_writes", 64'(hi_seen), 0);
    end

    // Back-to-back SUBs with instr_valid held high
    begin
      int acc = 0, acc2_k = -1, done1_k = -1, ndone = 0, nwb = 0;
      logic [31:0] wd [2];
      logic [3:0]  ws [2];
      logic take;
      regs[4] = 32'd9; regs[5] = 32'd4;
      instr = {5'b00100, 4'd4, 4'd5, 4'd6, 15'd0};
      instr_valid = 1'b1;
      for (int k = 0; k < 14; k++) begin
        if (wb_en) begin
          if (nwb < 2) begin wd[nwb] = wb_data; ws[nwb] = wb_sel; end
          nwb++;
        end
        if (done) begin ndone++; if (done1_k < 0) done1_k = k; end
        take = instr_ready && instr_valid;
        @(posedge clock); #1;
        if (take) begin
          acc++;
          if (acc == 1) instr = {5'b00100, 4'd5, 4'd4, 4'd7, 15'd0};
          else begin instr_valid = 1'b0; acc2_k = k; end
        end
      end
      chk("b2b_accepts", 64'(acc), 2);
      chk("b2b_second_after_done", 64'(acc2_k), 64'(done1_k + 1));
      chk("b2b_writes", 64'({nwb, ndone}), 64'({32'd2, 32'd2}));
      chk("b2b_first", {ws[0], wd[0]}, {4'd6, 32'd5});
      chk("b2b_second", {ws[1], wd[1]}, {4'd7, 32'hFFFFFFFB});
    end

`ifdef ALU_FLAGS_EN
    begin
      vec_t fv;
      fv = '{5'b00100, 4'd1, 4'd2, 4'd3, 32'd3, 32'd3, 0, 32'd0, 32'd0};
      run_vec(fv);
      chk("flags_sub_zero", {flag_z, flag_n}, 2'b10);
      fv = '{5'b10001, 4'd1, 4'd2, 4'd3, 32'd1, 32'd0, 0, 32'hFFFFFFFF, 32'd0};
      run_vec(fv);
      chk("flags_neg", {flag_z, flag_n}, 2'b01);
      run_vec(vecs[10]);
      chk("flags_hold_illegal", {flag_z, flag_n}, 2'b01);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
